// File: rtl/rs_pool.sv
// Reservation station: buffers renamed instructions, snoops the CDB for operands
// and issues the oldest ready entry through a valid/ready output register.
module rs_pool #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int CDB_N  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_op,
    input  logic [TAG_W-1:0]             in_qj,
    input  logic [TAG_W-1:0]             in_qk,
    input  logic [DATA_W-1:0]            in_vj,
    input  logic [DATA_W-1:0]            in_vk,
    input  logic [DATA_W-1:0]            in_pc,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [TAG_W-1:0]             in_dest,
    input  logic [CDB_N-1:0]             cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]       cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]      cdb_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OP_W-1:0]              out_op,
    output logic [DATA_W-1:0]            out_vj,
    output logic [DATA_W-1:0]            out_vk,
    output logic [DATA_W-1:0]            out_pc,
    output logic [DATA_W-1:0]            out_imm,
    output logic [TAG_W-1:0]             out_dest,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  busy_reg;
    logic [OP_W-1:0]   op_reg   [DEPTH];
    logic [TAG_W-1:0]  qj_reg   [DEPTH];
    logic [TAG_W-1:0]  qk_reg   [DEPTH];
    logic [DATA_W-1:0] vj_reg   [DEPTH];
    logic [DATA_W-1:0] vk_reg   [DEPTH];
    logic [DATA_W-1:0] pc_reg   [DEPTH];
    logic [DATA_W-1:0] imm_reg  [DEPTH];
    logic [TAG_W-1:0]  dest_reg [DEPTH];
    logic [DEPTH-1:0]  older_reg [DEPTH];
    logic [CNT_W-1:0]  count_reg;

    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  sel;
    logic [DATA_W:0]   hit_j [DEPTH];
    logic [DATA_W:0]   hit_k [DEPTH];
    logic [DATA_W:0]   in_hit_j;
    logic [DATA_W:0]   in_hit_k;
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  sidx;
    logic              any_ready;
    logic              out_free;
    logic              disp_fire;
    logic              issue_fire;

    // Returns {hit, data}; the lowest-numbered matching port wins, tag 0 never matches.
    function automatic logic [DATA_W:0] snoop(
        input logic [TAG_W-1:0]        tag,
        input logic [CDB_N-1:0]        bvalid,
        input logic [CDB_N*TAG_W-1:0]  btag,
        input logic [CDB_N*DATA_W-1:0] bdata
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (bvalid[k] && (tag != '0) && (btag[k*TAG_W +: TAG_W] == tag))
                r = {1'b1, bdata[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic blocked;
        assign hit_j[gi] = snoop(qj_reg[gi], cdb_valid, cdb_tag, cdb_data);
        assign hit_k[gi] = snoop(qk_reg[gi], cdb_valid, cdb_tag, cdb_data);
        assign ready[gi] = busy_reg[gi] && (qj_reg[gi] == '0) && (qk_reg[gi] == '0);
        always_comb begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_reg[j][gi])
                    blocked = 1'b1;
            end
        end
        assign sel[gi] = ready[gi] && !blocked;
    end

    // sel is one-hot whenever anything is ready, so the encoder order is irrelevant.
    always_comb begin
        widx = '0;
        sidx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_reg[i])
                widx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i])
                sidx = IDX_W'(i);
        end
    end

    assign in_hit_j   = snoop(in_qj, cdb_valid, cdb_tag, cdb_data);
    assign in_hit_k   = snoop(in_qk, cdb_valid, cdb_tag, cdb_data);
    assign any_ready  = |ready;
    assign out_free   = !out_valid || out_ready;
    assign in_ready   = rst && (count_reg < CNT_W'(DEPTH));
    assign disp_fire  = in_valid && in_ready && ena && !flush;
    assign issue_fire = ena && !flush && out_free && any_ready;
    assign count      = count_reg;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            busy_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && (widx == IDX_W'(i))) begin
                    busy_reg[i]  <= 1'b1;
                    op_reg[i]    <= in_op;
                    pc_reg[i]    <= in_pc;
                    imm_reg[i]   <= in_imm;
                    dest_reg[i]  <= in_dest;
                    qj_reg[i]    <= in_hit_j[DATA_W] ? '0 : in_qj;
                    vj_reg[i]    <= in_hit_j[DATA_W] ? in_hit_j[DATA_W-1:0] : in_vj;
                    qk_reg[i]    <= in_hit_k[DATA_W] ? '0 : in_qk;
                    vk_reg[i]    <= in_hit_k[DATA_W] ? in_hit_k[DATA_W-1:0] : in_vk;
                    older_reg[i] <= '0;
                end else begin
                    if (issue_fire && (sidx == IDX_W'(i)))
                        busy_reg[i] <= 1'b0;
                    if (busy_reg[i] && hit_j[i][DATA_W]) begin
                        qj_reg[i] <= '0;
                        vj_reg[i] <= hit_j[i][DATA_W-1:0];
                    end
                    if (busy_reg[i] && hit_k[i][DATA_W]) begin
                        qk_reg[i] <= '0;
                        vk_reg[i] <= hit_k[i][DATA_W-1:0];
                    end
                    if (disp_fire && busy_reg[i])
                        older_reg[i][widx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_vj    <= '0;
            out_vk    <= '0;
            out_pc    <= '0;
            out_imm   <= '0;
            out_dest  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (ena && out_free) begin
            out_valid <= any_ready;
            if (any_ready) begin
                out_op   <= op_reg[sidx];
                out_vj   <= vj_reg[sidx];
                out_vk   <= vk_reg[sidx];
                out_pc   <= pc_reg[sidx];
                out_imm  <= imm_reg[sidx];
                out_dest <= dest_reg[sidx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush)
            count_reg <= '0;
        else if (disp_fire && !issue_fire)
            count_reg <= count_reg + 1'b1;
        else if (!disp_fire && issue_fire)
            count_reg <= count_reg - 1'b1;
    end
endmodule

// File: tb/tb_rs_pool.sv
// Self-checking bench for rs_pool: directed scenarios plus random traffic against
// an age-ordered queue model of the pool and its issue register.
module tb_rs_pool;
    localparam int DEPTH = 8;
    localparam int CDB_N = 2;

    logic        clk = 1'b0;
    logic        rst, ena, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  in_op, out_op;
    logic [3:0]  in_qj, in_qk, in_dest, out_dest;
    logic [31:0] in_vj, in_vk, in_pc, in_imm;
    logic [31:0] out_vj, out_vk, out_pc, out_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic [3:0]  count;

    rs_pool dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_qj(in_qj), .in_qk(in_qk), .in_vj(in_vj), .in_vk(in_vk),
        .in_pc(in_pc), .in_imm(in_imm), .in_dest(in_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_vj(out_vj), .out_vk(out_vk), .out_pc(out_pc), .out_imm(out_imm),
        .out_dest(out_dest), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          seq;
        logic [5:0]  op;
        logic [3:0]  qj, qk, dest;
        logic [31:0] vj, vk, pc, imm;
    } ent_t;

    ent_t        mq[$];
    int          m_seq = 0;
    logic        m_ov = 1'b0;
    logic [5:0]  m_op = '0;
    logic [31:0] m_vj = '0, m_vk = '0, m_pc = '0, m_imm = '0;
    logic [3:0]  m_dest = '0;

    logic [31:0] seen_dest[$], seen_vj[$], seen_vk[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operand capture: the first listed port carrying the waited-for tag supplies the value.
    function automatic logic [35:0] cap(input logic [3:0] t, input logic [31:0] v);
        logic [35:0] r;
        bit          found;
        r = {t, v};
        found = 0;
        if (t != 4'd0) begin
            for (int k = 0; k < CDB_N; k++) begin
                if (!found && cdb_valid[k] && cdb_tag[k*4 +: 4] == t) begin
                    r = {4'd0, cdb_data[k*32 +: 32]};
                    found = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic model_step();
        int   best;
        ent_t e;
        bit   irdy;
        irdy = rst && (mq.size() < DEPTH);
        if (!rst) begin
            mq.delete();
            m_ov = 0; m_op = '0; m_vj = '0; m_vk = '0; m_pc = '0; m_imm = '0; m_dest = '0;
        end else if (flush) begin
            mq.delete();
            m_ov = 0;
        end else begin
            best = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].qj == 4'd0 && mq[i].qk == 4'd0 && (best < 0 || mq[i].seq < mq[best].seq))
                    best = i;
            end
            if (ena && (!m_ov || out_ready)) begin
                if (best >= 0) begin
                    m_op = mq[best].op; m_vj = mq[best].vj; m_vk = mq[best].vk;
                    m_pc = mq[best].pc; m_imm = mq[best].imm; m_dest = mq[best].dest;
                    mq.delete(best);
                    m_ov = 1;
                end else begin
                    m_ov = 0;
                end
            end
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                {e.qj, e.vj} = cap(e.qj, e.vj);
                {e.qk, e.vk} = cap(e.qk, e.vk);
                mq[i] = e;
            end
            if (in_valid && irdy && ena) begin
                e.seq = m_seq; m_seq++;
                e.op = in_op; e.pc = in_pc; e.imm = in_imm; e.dest = in_dest;
                {e.qj, e.vj} = cap(in_qj, in_vj);
                {e.qk, e.vk} = cap(in_qk, in_vk);
                mq.push_back(e);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("count", 64'(count), 64'(mq.size()));
        check_eq("in_ready", 64'(in_ready), 64'((rst && mq.size() < DEPTH) ? 1 : 0));
        check_eq("out_valid", 64'(out_valid), 64'(m_ov));
        check_eq("out_op", 64'(out_op), 64'(m_op));
        check_eq("out_vj", 64'(out_vj), 64'(m_vj));
        check_eq("out_vk", 64'(out_vk), 64'(m_vk));
        check_eq("out_pc", 64'(out_pc), 64'(m_pc));
        check_eq("out_imm", 64'(out_imm), 64'(m_imm));
        check_eq("out_dest", 64'(out_dest), 64'(m_dest));
    endtask

    task automatic step();
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            seen_dest.push_back(32'(out_dest));
            seen_vj.push_back(out_vj);
            seen_vk.push_back(out_vk);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_idle();
        in_valid = 0; in_op = '0; in_qj = '0; in_qk = '0; in_vj = '0; in_vk = '0;
        in_pc = '0; in_imm = '0; in_dest = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        flush = 0; ena = 1;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] dest);
        in_valid = 1; in_op = op; in_qj = qj; in_qk = qk; in_vj = vj; in_vk = vk;
        in_dest = dest; in_pc = $urandom; in_imm = $urandom;
    endtask

    task automatic clear_seen();
        seen_dest.delete(); seen_vj.delete(); seen_vk.delete();
    endtask

    initial begin
        rst = 0; out_ready = 1;
        drive_idle();
        step(); step();
        rst = 1;
        step();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_op", 64'(out_op), 64'd0);

        // Ready dispatch: visible in the issue register two cycles later.
        dispatch(6'd3, 4'd0, 4'd0, 32'd5, 32'd7, 4'd2);
        step();
        drive_idle();
        step();
        check_eq("rd_out_valid", 64'(out_valid), 64'd1);
        check_eq("rd_out_op", 64'(out_op), 64'd3);
        check_eq("rd_out_vj", 64'(out_vj), 64'd5);
        check_eq("rd_out_vk", 64'(out_vk), 64'd7);
        check_eq("rd_out_dest", 64'(out_dest), 64'd2);
        check_eq("rd_count", 64'(count), 64'd0);
        step(); step();

        // Oldest-first wakeup: C wakes first, then A before B.
        clear_seen();
        dispatch(6'd1, 4'd4, 4'd0, 32'd0, 32'd11, 4'd10); step();
        dispatch(6'd2, 4'd4, 4'd0, 32'd0, 32'd12, 4'd11); step();
        dispatch(6'd3, 4'd5, 4'd0, 32'd0, 32'd13, 4'd12); step();
        drive_idle();
        cdb_valid = 2'b10; cdb_tag = 8'h50; cdb_data = {32'd9, 32'd0}; step();
        cdb_valid = 2'b01; cdb_tag = 8'h04; cdb_data = {32'd0, 32'd1}; step();
        drive_idle();
        for (int i = 0; i < 5; i++) step();
        check_eq("order_n", 64'(seen_dest.size()), 64'd3);
        if (seen_dest.size() >= 3) begin
            check_eq("order_0", 64'(seen_dest[0]), 64'd12);
            check_eq("order_1", 64'(seen_dest[1]), 64'd10);
            check_eq("order_2", 64'(seen_dest[2]), 64'd11);
            check_eq("order_vj_c", 64'(seen_vj[0]), 64'd9);
            check_eq("order_vj_a", 64'(seen_vj[1]), 64'd1);
            check_eq("order_vj_b", 64'(seen_vj[2]), 64'd1);
        end

        // Bypass at dispatch with both ports carrying the same tag.
        clear_seen();
        dispatch(6'd4, 4'd0, 4'd6, 32'd3, 32'd0, 4'd13);
        cdb_valid = 2'b11; cdb_tag = 8'h66; cdb_data = {32'hBB, 32'hAA};
        step();
        drive_idle();
        for (int i = 0; i < 4; i++) step();
        check_eq("byp_n", 64'(seen_dest.size()), 64'd1);
        if (seen_dest.size() >= 1)
            check_eq("byp_vk", 64'(seen_vk[0]), 64'hAA);

        // Fill under backpressure, then drain.
        out_ready = 0;
        for (int i = 0; i < 12; i++) begin
            dispatch(6'(i), 4'd0, 4'd0, $urandom, $urandom, 4'(i + 1));
            step();
        end
        drive_idle();
        check_eq("full_count", 64'(count), 64'd8);
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) step();
        out_ready = 1;
        step();
        check_eq("drain_in_ready", 64'(in_ready), 64'd1);
        check_eq("drain_count", 64'(count), 64'd7);
        for (int i = 0; i < 12; i++) step();

        // Flush with a simultaneous dispatch.
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            dispatch(6'd9, 4'd0, 4'd0, $urandom, $urandom, 4'd3);
            step();
        end
        drive_idle();
        step();
        check_eq("pre_flush_count", 64'(count), 64'd4);
        check_eq("pre_flush_valid", 64'(out_valid), 64'd1);
        dispatch(6'd5, 4'd0, 4'd0, 32'd1, 32'd2, 4'd9);
        flush = 1;
        step();
        drive_idle();
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        step();
        check_eq("flush_drop", 64'(count), 64'd0);

        // Wakeup captured while stalled.
        out_ready = 1;
        clear_seen();
        dispatch(6'd7, 4'd7, 4'd0, 32'd0, 32'd4, 4'd14);
        step();
        drive_idle();
        ena = 0; cdb_valid = 2'b01; cdb_tag = 8'h07; cdb_data = {32'd0, 32'h55};
        step();
        cdb_valid = 2'b00;
        step(); step();
        check_eq("stall_valid", 64'(out_valid), 64'd0);
        ena = 1;
        for (int i = 0; i < 3; i++) step();
        check_eq("stall_n", 64'(seen_dest.size()), 64'd1);
        if (seen_dest.size() >= 1) begin
            check_eq("stall_dest", 64'(seen_dest[0]), 64'd14);
            check_eq("stall_vj", 64'(seen_vj[0]), 64'h55);
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) != 0);
            ena       = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 6'($urandom);
            in_qj     = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 7));
            in_qk     = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 7));
            in_vj     = $urandom; in_vk = $urandom; in_pc = $urandom; in_imm = $urandom;
            in_dest   = 4'($urandom);
            cdb_valid = 2'($urandom_range(0, 3));
            cdb_tag   = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            cdb_data  = {$urandom, $urandom};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
